// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : inv_sub_bytes_seq
// Description : Sequential AES InvSubBytes engine, BYTES_PER_CYCLE shared
//               S-box lookups per cycle, valid/ready on both sides.
//               Optional macro INV_SUB_BYTES_FWD_EN adds a forward-S-box mode.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic         mode,
`endif
    input  logic [0:127] msg,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] msgout,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int C_NCHUNK = 16 / BYTES_PER_CYCLE;
    localparam int C_CW     = (C_NCHUNK > 1) ? $clog2(C_NCHUNK) : 1;
    localparam int C_LOGB   = $clog2(BYTES_PER_CYCLE);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_BUSY = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
            $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // GF(2^8) arithmetic, used only to build the constant lookup tables
    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
    function automatic logic [7:0] f_ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = f_gmul(r, p);
            p = f_gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [2047:0] f_build_inv();
        logic [2047:0] t;
        logic [7:0]    b;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            t[8*i +: 8] = f_ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
        end
        return t;
    endfunction

    localparam logic [2047:0] C_INV_SBOX = f_build_inv();

`ifdef INV_SUB_BYTES_FWD_EN
    function automatic logic [2047:0] f_build_fwd();
        logic [2047:0] t;
        logic [7:0]    v;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            v = f_ginv(8'(i));
            t[8*i +: 8] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
                          {v[3:0], v[7:4]} ^ 8'h63;
        end
        return t;
    endfunction

    localparam logic [2047:0] C_FWD_SBOX = f_build_fwd();

    logic r_mode;
`endif

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [0:127]    r_msg_in;
    logic [0:127]    r_msgout;
    logic [C_CW-1:0] r_cnt;
    logic            w_last;
    logic            w_accept;
    logic [3:0]      w_chunk_base;
    logic [7:0]      w_lane_in [BYTES_PER_CYCLE];
    logic [7:0]      w_sub     [BYTES_PER_CYCLE];

    assign w_last       = (r_cnt == C_CW'(C_NCHUNK - 1));
    assign w_accept     = (r_state == C_ST_IDLE) && in_valid;
    assign w_chunk_base = 4'(r_cnt) << C_LOGB;
    assign msgout       = r_msgout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = C_ST_BUSY;
            end
            C_ST_BUSY: begin
                if (w_last) w_state_nxt = C_ST_DONE;
            end
            C_ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = C_ST_IDLE;
            end
            default: w_state_nxt = C_ST_IDLE;
        endcase
    end

    // Lane j of chunk c handles byte c*B+j of the captured state
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            w_lane_in[j] = r_msg_in[{w_chunk_base + 4'(j), 3'b000} +: 8];
`ifdef INV_SUB_BYTES_FWD_EN
            w_sub[j] = r_mode ? C_FWD_SBOX[{w_lane_in[j], 3'b000} +: 8]
                              : C_INV_SBOX[{w_lane_in[j], 3'b000} +: 8];
`else
            w_sub[j] = C_INV_SBOX[{w_lane_in[j], 3'b000} +: 8];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg_in <= '0;
            r_msgout <= '0;
            r_cnt    <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
            r_mode   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_msg_in <= msg;
            r_cnt    <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
            r_mode   <= mode;
`endif
        end else if (r_state == C_ST_BUSY) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            for (int k = 0; k < 16; k++) begin
                if (r_cnt == C_CW'(k / BYTES_PER_CYCLE)) begin
                    r_msgout[8*k +: 8] <= w_sub[k % BYTES_PER_CYCLE];
                end
            end
        end
    end

endmodule
`default_nettype wire
